// File: rtl/sprite_row_fetch.sv
// sprite_row_fetch: turns the raster position into sprite ROM word addresses
// and serialises each fetched word into one sprite bit per pixel strobe.
// One sprite row is SPRITE_DIM/WORD_W words; ROM address = {row, word}.
module sprite_row_fetch #(
  parameter int COORD_W    = 10,
  parameter int SPRITE_DIM = 64,
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  input  logic               visible,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [WORD_W-1:0]  rom_dout,
  output logic               pixel_on,
  output logic               in_sprite
);

  localparam int ROW_W = $clog2(SPRITE_DIM);
  localparam int SEL_W = ADDR_W - ROW_W;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int WORDS = SPRITE_DIM / WORD_W;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  sx_q, sx_d;
  logic [COORD_W-1:0]  sy_q, sy_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                pixel_on_q, pixel_on_d;
  logic                in_sprite_q, in_sprite_d;

  logic [COORD_W:0]    vdiff;
  logic [ROW_W-1:0]    row;
  logic                row_hit;
  logic                start_hit;
  logic                line_done;

  // One extra bit keeps vcount < sy from wrapping into a false hit.
  assign vdiff     = {1'b0, vcount} - {1'b0, sy_q};
  assign row       = vdiff[ROW_W-1:0];
  assign row_hit   = (vcount >= sy_q) && (vdiff < (COORD_W+1)'(SPRITE_DIM));
  assign start_hit = visible && row_hit && (hcount == sx_q);
  // Leave ACTIVE on blanking, leaving the sprite rows, or after the last bit of the last word.
  assign line_done = !visible || !row_hit ||
                     ((bit_cnt_q == '0) && (word_cnt_q == SEL_W'(WORDS-1)));

  // Shadow sprite position: only picked up at the first pixel of a frame so a move never tears.
  always_comb begin
    sx_d = sx_q;
    sy_d = sy_q;
    if (pix_en && (hcount == '0) && (vcount == '0)) begin
      sx_d = sprite_x;
      sy_d = sprite_y;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: start at the sprite's left edge, fall back to IDLE at line end or abort.
  always_comb begin
    state_d = state_q;
    if (pix_en) begin
      case (state_q)
        S_IDLE:   if (start_hit) state_d = S_ACTIVE;
        default:  if (line_done) state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath logic: word capture, bit serialisation and ROM address sequencing.
  always_comb begin
    pixel_on_d  = pixel_on_q;
    in_sprite_d = in_sprite_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    rom_addr_d  = rom_addr_q;
    case (state_q)
      S_IDLE: begin
        // Keep word 0 of the current row presented so it is stable when the start pixel arrives.
        rom_addr_d = {row, SEL_W'(0)};
        if (pix_en) begin
          pixel_on_d  = 1'b0;
          in_sprite_d = 1'b0;
          if (start_hit) begin
            pixel_on_d  = rom_dout[WORD_W-1];
            in_sprite_d = 1'b1;
            shift_d     = rom_dout << 1;
            bit_cnt_d   = BIT_W'(1);
            word_cnt_d  = '0;
            rom_addr_d  = {row, SEL_W'(1)};
          end
        end
      end
      default: begin
        if (pix_en) begin
          if (line_done) begin
            pixel_on_d  = 1'b0;
            in_sprite_d = 1'b0;
            rom_addr_d  = {row, SEL_W'(0)};
          end else if (bit_cnt_q == '0) begin
            // Next word was addressed 16 strobes ago; fetch it and point at the one after.
            pixel_on_d  = rom_dout[WORD_W-1];
            in_sprite_d = 1'b1;
            shift_d     = rom_dout << 1;
            bit_cnt_d   = BIT_W'(1);
            word_cnt_d  = word_cnt_q + SEL_W'(1);
            rom_addr_d  = {row, word_cnt_q + SEL_W'(2)};
          end else begin
            pixel_on_d  = shift_q[WORD_W-1];
            in_sprite_d = 1'b1;
            shift_d     = shift_q << 1;
            bit_cnt_d   = bit_cnt_q + BIT_W'(1);
          end
        end
      end
    endcase
  end

  // Datapath and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rom_addr_q  <= '0;
      pixel_on_q  <= 1'b0;
      in_sprite_q <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      rom_addr_q  <= rom_addr_d;
      pixel_on_q  <= pixel_on_d;
      in_sprite_q <= in_sprite_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pixel_on  = pixel_on_q;
  assign in_sprite = in_sprite_q;

endmodule

// File: doc/sprite_row_fetch.md
# sprite_row_fetch

Sprite scan-out stage sitting directly in front of a 256×16 sprite ROM (8-bit address, 16-bit word, asynchronous combinational read). It turns the VGA raster position into ROM word addresses and serializes each 16-bit word into one bit per pixel. The output `pixel_on` goes to the colour mux. One 64×64, 1-bpp sprite is stored as 64 rows of 4 words, so word address = {row[5:0], word[1:0]}.

## Interface
- `COORD_W`, default 10: width of the raster and sprite coordinates.
- `SPRITE_DIM`, default 64: sprite width and height in pixels. Fixed; the ROM layout depends on it.
- `WORD_W`, default 16: ROM data width, giving pixels per word.
- `ADDR_W`, default 8: ROM address width.
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `pix_en`  in  1: one-cycle pixel strobe. All raster state advances only on cycles where it is high.
- `visible`  in  1: raster is inside the active display area.
- `hcount`  in  COORD_W: current pixel column.
- `vcount`  in  COORD_W: current pixel row.
- `sprite_x`  in  COORD_W: requested left edge of the sprite.
- `sprite_y`  in  COORD_W: requested top edge of the sprite.
- `rom_addr`  out  ADDR_W: registered ROM word address.
- `rom_dout`  in  WORD_W: ROM word, combinationally valid in the same cycle as `rom_addr`.
- `pixel_on`  out  1: registered sprite bit for the pixel strobed on the previous `pix_en`.
- `in_sprite`  out  1: registered flag, high while `pixel_on` belongs to the sprite window.

## Operation
- **Shadow coordinates:** `sx`/`sy` load from `sprite_x`/`sprite_y` on `pix_en` when hcount==0 and vcount==0. This limits sprite moves to frame boundaries, so there is no tearing.
- **Row tracking:**
  - `row` = vcount − sy, truncated to 6 bits.
  - `row_hit` = (vcount ≥ sy) and (vcount − sy < 64), compared at COORD_W+1 bits with no wrap.
- **State IDLE:**
  - Each clk, `rom_addr` ← {row, 2'b00}.
  - `pixel_on` = 0, `in_sprite` = 0 on every `pix_en`.
  - On `pix_en` with visible & row_hit & hcount==sx: capture `rom_dout`.
    - `pixel_on` ← rom_dout[15]; `in_sprite` ← 1.
    - shift ← rom_dout<<1; bit_cnt ← 1; word_cnt ← 0.
    - `rom_addr` ← {row, 2'b01}; go to ACTIVE.
- **State ACTIVE, on each `pix_en`:**
  - If !visible or !row_hit: abort to IDLE, `pixel_on` ← 0, `in_sprite` ← 0.
  - Else if bit_cnt==0: load the new word exactly as in IDLE.
    - The new word is at word_cnt+1; its address is already stable.
    - `rom_addr` advances to the following word. Wrap on word 3 is don't-care; it is reloaded in IDLE.
  - Otherwise: `pixel_on` ← shift[15]; shift ← shift<<1; `in_sprite` ← 1.
  - bit_cnt is 4 bits and wraps 15→0. word_cnt increments when bit_cnt wraps.
  - After the pixel with word_cnt==3 and bit_cnt==15 is emitted, the next `pix_en` goes to IDLE with `pixel_on` = `in_sprite` = 0. That is exactly 64 pixels.
- **Bit order:** MSB is the leftmost pixel.
- **Cycles without `pix_en`:** all state holds. In IDLE only `rom_addr` is refreshed.
- **Right-edge clipping:** if sx+64 exceeds the visible width, `visible` falls and aborts the line. The next line restarts at word 0.
- **Sprite start column:** sx==0 is legal; the trigger is on hcount==0.

## Timing
- **Reset (asynchronous, `reset_n` low):** state IDLE; `rom_addr`=0, `pixel_on`=0, `in_sprite`=0; sx=sy=0; counters and shift register 0.
- **Reset mid-line:** outputs go to 0 immediately; the sprite resumes at the next qualifying line start.
- **Latency:** `pixel_on`/`in_sprite` for the pixel at (hcount, vcount) are valid one clk after its `pix_en` edge and hold until the next `pix_en` edge.
- **ROM address stability:** each `rom_addr` value is stable for ≥1 clk before the `pix_en` edge that samples `rom_dout`. The ROM read stays combinational; no extra wait state.
- **Throughput:** back-to-back `pix_en` on every clk is supported.

## Test plan
- **Single line:** ROM row 5 = {16'hF00F, 16'h8001, 16'hAAAA, 16'h0000}; sx=100, sy=20; raster to vcount=25, `pix_en` every clk.
  - `rom_addr` goes 0x14, 0x15, 0x16, 0x17.
  - `pixel_on` is high for hcount 100–103, 112–115, 116, 131 and the even offsets of 132–147.
  - `in_sprite` is high for exactly hcount 100–163, each one clk late.
- **Strobe gaps:** same as the single-line case with `pix_en` 1-in-4 → identical pixel sequence; outputs hold between strobes.
- **Mid-frame move:** change sprite_x to 200 at vcount=30 → no shift until the next frame. After that, the first `in_sprite` appears at hcount=200.
- **Clipping:** sx=600, visible width 640 → 40 pixels output; abort at hcount 640. The next line starts at `rom_addr`={row+1, 00}.
- **Edges:** sy=0 and sy=416 → vertical window bounds are exact. vcount=sy+63 is drawn with address {6'd63, xx}; vcount=sy+64 is not drawn.
- **Async reset:** assert `reset_n` at bit 7 of word 2 → `pixel_on`, `in_sprite` and `rom_addr` are 0 before the next clk edge. After release, the following qualifying line is drawn from word 0.
